apb_completer: RTL and testbench



---
 rtl/apb_pkg.sv | 19 +
 rtl/apb_regfile.sv | 33 +++
 rtl/apb_completer.sv | 139 +++++++++++++
 tb/tb_apb_completer.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// Shared APB definitions: bus widths plus the requester and completer state encodings.
package apb_pkg;

    localparam int APB_ADDR_W = 32;
    localparam int APB_DATA_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } apb_cmp_state_t;

    typedef enum logic [1:0] {
        REQ_IDLE   = 2'd0,
        REQ_SETUP  = 2'd1,
        REQ_ACCESS = 2'd2
    } apb_req_state_t;

endpackage

// File: rtl/apb_regfile.sv
// Flop-based word store behind the APB completer: one synchronous write port,
// one combinational read port, every word cleared by reset.
module apb_regfile
    import apb_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  we,
    input  logic [IDX_W-1:0]      widx,
    input  logic [APB_DATA_W-1:0] wdata,
    input  logic [IDX_W-1:0]      ridx,
    output logic [APB_DATA_W-1:0] rdata
);

    logic [APB_DATA_W-1:0] mem [DEPTH];

    // Clear the whole array on reset, otherwise commit a single-word write.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[widx] <= wdata;
        end
    end

    assign rdata = mem[ridx];

endmodule

// File: rtl/apb_completer.sv
// APB completer backing a window of DEPTH words at BASE_ADDR, with a fixed number
// of wait states per access and pslverr for any address outside the window.
module apb_completer
    import apb_pkg::*;
#(
    parameter logic [APB_ADDR_W-1:0] BASE_ADDR   = 32'hDEAD_CA00,
    parameter int                    DEPTH       = 64,
    parameter int                    WAIT_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  psel,
    input  logic                  penable,
    input  logic [APB_ADDR_W-1:0] paddr,
    input  logic                  pwrite,
    input  logic [APB_DATA_W-1:0] pwdata,
    output logic [APB_DATA_W-1:0] prdata,
    output logic                  pready,
    output logic                  pslverr
);

    localparam int                    IDX_W        = $clog2(DEPTH);
    localparam logic [APB_ADDR_W-1:0] WINDOW_BYTES = APB_ADDR_W'(4 * DEPTH);

    apb_cmp_state_t        state;
    logic [3:0]            wait_cnt;
    logic                  cap_write;
    logic                  cap_hit;
    logic [IDX_W-1:0]      cap_idx;
    logic [APB_DATA_W-1:0] cap_wdata;

    logic [APB_ADDR_W-1:0] offset;
    logic                  live_hit;
    logic [IDX_W-1:0]      live_idx;

    logic                  resp_write;
    logic                  resp_hit;
    logic [IDX_W-1:0]      resp_idx;
    logic [APB_DATA_W-1:0] rd_word;
    logic                  mem_we;

    // A paddr below the base wraps to a huge offset, so the lower-bound test
    // only matters for windows sitting near the top of the address space.
    assign offset   = paddr - BASE_ADDR;
    assign live_hit = (paddr >= BASE_ADDR) && (offset < WINDOW_BYTES);
    assign live_idx = offset[IDX_W+1:2];

    // With zero wait states the response is loaded straight out of setup, before
    // the captured copy exists, so the live decode is used while still idle.
    always_comb begin
        resp_write = cap_write;
        resp_hit   = cap_hit;
        resp_idx   = cap_idx;
        if (state == ST_IDLE) begin
            resp_write = pwrite;
            resp_hit   = live_hit;
            resp_idx   = live_idx;
        end
    end

    assign mem_we = (state == ST_RESP) && psel && penable && cap_write && cap_hit;

    apb_regfile #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_regfile (
        .clk   (clk),
        .reset (reset),
        .we    (mem_we),
        .widx  (cap_idx),
        .wdata (cap_wdata),
        .ridx  (resp_idx),
        .rdata (rd_word)
    );

    // Transfer FSM: capture at setup, count wait states, hold the registered response until completion.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            wait_cnt  <= '0;
            cap_write <= 1'b0;
            cap_hit   <= 1'b0;
            cap_idx   <= '0;
            cap_wdata <= '0;
            pready    <= 1'b0;
            pslverr   <= 1'b0;
            prdata    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (psel && !penable) begin
                        cap_write <= pwrite;
                        cap_hit   <= live_hit;
                        cap_idx   <= live_idx;
                        cap_wdata <= pwdata;
                        wait_cnt  <= 4'(WAIT_CYCLES);
                        if (WAIT_CYCLES > 0) begin
                            state <= ST_WAIT;
                        end else begin
                            state   <= ST_RESP;
                            pready  <= 1'b1;
                            pslverr <= !resp_hit;
                            prdata  <= (resp_hit && !resp_write) ? rd_word : '0;
                        end
                    end
                end
                ST_WAIT: begin
                    if (!psel) begin
                        state    <= ST_IDLE;
                        wait_cnt <= '0;
                    end else if (wait_cnt == 4'd1) begin
                        state    <= ST_RESP;
                        wait_cnt <= '0;
                        pready   <= 1'b1;
                        pslverr  <= !resp_hit;
                        prdata   <= (resp_hit && !resp_write) ? rd_word : '0;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                ST_RESP: begin
                    if (!psel || penable) begin
                        state   <= ST_IDLE;
                        pready  <= 1'b0;
                        pslverr <= 1'b0;
                        prdata  <= '0;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    pready  <= 1'b0;
                    pslverr <= 1'b0;
                    prdata  <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_completer.sv
// Scoreboard bench for apb_completer: a WAIT_CYCLES=2 instance and a WAIT_CYCLES=0
// instance driven by directed and random transfers, checked against a word-array model.
module tb_apb_completer;
    import apb_pkg::*;

    localparam logic [31:0] BASE = 32'hDEAD_CA00;

    typedef struct {
        logic [31:0] data;
        logic        err;
        string       name;
    } exp_t;

    logic        clk;
    logic        reset   [2];
    logic        psel    [2];
    logic        penable [2];
    logic        pwrite  [2];
    logic [31:0] paddr   [2];
    logic [31:0] pwdata  [2];
    logic [31:0] prdata  [2];
    logic        pready  [2];
    logic        pslverr [2];

    logic [31:0] model [2][64];
    exp_t        exp_q0 [$];
    exp_t        exp_q1 [$];
    int          total = 0;
    int          bad   = 0;

    apb_completer #(.BASE_ADDR(BASE), .DEPTH(64), .WAIT_CYCLES(2)) u_dut0 (
        .clk(clk), .reset(reset[0]), .psel(psel[0]), .penable(penable[0]),
        .paddr(paddr[0]), .pwrite(pwrite[0]), .pwdata(pwdata[0]),
        .prdata(prdata[0]), .pready(pready[0]), .pslverr(pslverr[0])
    );

    apb_completer #(.BASE_ADDR(BASE), .DEPTH(64), .WAIT_CYCLES(0)) u_dut1 (
        .clk(clk), .reset(reset[1]), .psel(psel[1]), .penable(penable[1]),
        .paddr(paddr[1]), .pwrite(pwrite[1]), .pwdata(pwdata[1]),
        .prdata(prdata[1]), .pready(pready[1]), .pslverr(pslverr[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    function automatic bit model_hit(input logic [31:0] a);
        longint unsigned x;
        x = a;
        return (x >= 64'(BASE)) && (x < 64'(BASE) + 64'd256);
    endfunction

    function automatic int model_idx(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        return int'(off / 4) % 64;
    endfunction

    task automatic idle(input int d, input int n);
        psel[d]    = 1'b0;
        penable[d] = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One full transfer: expected response is queued at setup, completion is timed here.
    task automatic apply_stimulus(input int d, input bit wr, input logic [31:0] addr, input logic [31:0] data);
        exp_t e;
        int   n;
        bit   hit;
        int   idx;
        int   exp_wait;
        hit      = model_hit(addr);
        idx      = model_idx(addr);
        exp_wait = (d == 0) ? 2 : 0;
        e.err    = !hit;
        e.data   = (hit && !wr) ? model[d][idx] : 32'h0;
        e.name   = wr ? $sformatf("dut%0d wr %h", d, addr) : $sformatf("dut%0d rd %h", d, addr);
        if (d == 0) exp_q0.push_back(e); else exp_q1.push_back(e);
        psel[d]    = 1'b1;
        penable[d] = 1'b0;
        pwrite[d]  = wr;
        paddr[d]   = addr;
        pwdata[d]  = data;
        @(posedge clk);
        #1;
        penable[d] = 1'b1;
        paddr[d]   = $urandom;
        pwdata[d]  = $urandom;
        n = 0;
        while (!pready[d] && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!pready[d]) begin
            check_output($sformatf("%s pready timeout", e.name), 32'(pready[d]), 32'd1);
            if (d == 0) void'(exp_q0.pop_back()); else void'(exp_q1.pop_back());
            idle(d, 1);
            return;
        end
        check_output($sformatf("%s latency", e.name), 32'(n), 32'(exp_wait));
        @(posedge clk);
        #1;
        if (wr && hit) model[d][idx] = data;
        psel[d]    = 1'b0;
        penable[d] = 1'b0;
    endtask

    // Monitor: every cycle a completer shows pready, its response is scored against the queue head.
    always @(negedge clk) begin
        exp_t e;
        for (int d = 0; d < 2; d++) begin
            if (!reset[d] && pready[d]) begin
                if ((d == 0 && exp_q0.size() == 0) || (d == 1 && exp_q1.size() == 0)) begin
                    check_output($sformatf("dut%0d unexpected pready", d), 32'(pready[d]), 32'd0);
                end else begin
                    if (d == 0) e = exp_q0.pop_front(); else e = exp_q1.pop_front();
                    check_output($sformatf("%s prdata", e.name), prdata[d], e.data);
                    check_output($sformatf("%s pslverr", e.name), 32'(pslverr[d]), 32'(e.err));
                end
            end
        end
    end

    initial begin
        logic [31:0] a;
        logic [31:0] v;
        for (int d = 0; d < 2; d++) begin
            reset[d] = 1'b1; psel[d] = 1'b0; penable[d] = 1'b0;
            pwrite[d] = 1'b0; paddr[d] = '0; pwdata[d] = '0;
            for (int i = 0; i < 64; i++) model[d][i] = 32'h0;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            check_output($sformatf("dut%0d reset pready", d), 32'(pready[d]), 32'd0);
            check_output($sformatf("dut%0d reset prdata", d), prdata[d], 32'h0);
            check_output($sformatf("dut%0d reset pslverr", d), 32'(pslverr[d]), 32'd0);
            reset[d] = 1'b0;
        end
        idle(0, 1);

        // Directed traffic on the two-wait-state instance.
        apply_stimulus(0, 1'b0, 32'hDEAD_CA00, 32'h0);
        apply_stimulus(0, 1'b1, 32'hDEAD_CAFE, 32'h1234_5678);
        apply_stimulus(0, 1'b0, 32'hDEAD_CAFC, 32'h0);
        apply_stimulus(0, 1'b0, 32'hDEAD_CB00, 32'h0);
        apply_stimulus(0, 1'b1, 32'h0000_0000, 32'hFFFF_FFFF);
        apply_stimulus(0, 1'b0, 32'hDEAD_C9FC, 32'h0);
        apply_stimulus(0, 1'b0, 32'hDEAD_CA00, 32'h0);
        apply_stimulus(0, 1'b0, 32'hDEAD_CAFF, 32'h0);

        // Write dropped by psel going low during the wait states.
        psel[0] = 1'b1; penable[0] = 1'b0; pwrite[0] = 1'b1;
        paddr[0] = 32'hDEAD_CA04; pwdata[0] = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        penable[0] = 1'b1;
        @(posedge clk); #1;
        idle(0, 2);
        check_output("abort pready", 32'(pready[0]), 32'd0);
        apply_stimulus(0, 1'b0, 32'hDEAD_CA04, 32'h0);

        // Zero-wait instance: back-to-back write/read/write/read on index 5.
        idle(1, 1);
        apply_stimulus(1, 1'b1, 32'hDEAD_CA14, 32'h1111_0005);
        apply_stimulus(1, 1'b0, 32'hDEAD_CA14, 32'h0);
        apply_stimulus(1, 1'b1, 32'hDEAD_CA14, 32'h2222_0005);
        apply_stimulus(1, 1'b0, 32'hDEAD_CA14, 32'h0);
        idle(1, 1);

        // Random mix of hits and misses on both instances.
        for (int k = 0; k < 80; k++) begin
            int d;
            d = k % 2;
            case ($urandom_range(0, 3))
                0, 1:    a = BASE + 32'($urandom_range(0, 63)) * 4 + 32'($urandom_range(0, 3));
                2:       a = BASE + 32'd256 + 32'($urandom_range(0, 63)) * 4;
                default: a = $urandom;
            endcase
            apply_stimulus(d, 1'($urandom_range(0, 1)), a, $urandom);
            idle(d, $urandom_range(0, 1));
        end

        // Reset during the wait states of a write.
        psel[0] = 1'b1; penable[0] = 1'b0; pwrite[0] = 1'b1;
        paddr[0] = 32'hDEAD_CA08; pwdata[0] = 32'hA5A5_A5A5;
        @(posedge clk); #1;
        penable[0] = 1'b1;
        reset[0] = 1'b1;
        @(posedge clk); #1;
        check_output("mid reset pready", 32'(pready[0]), 32'd0);
        check_output("mid reset state", 32'(u_dut0.state), 32'(ST_IDLE));
        reset[0] = 1'b0;
        for (int i = 0; i < 64; i++) model[0][i] = 32'h0;
        idle(0, 1);
        apply_stimulus(0, 1'b0, 32'hDEAD_CA08, 32'h0);
        apply_stimulus(0, 1'b0, 32'hDEAD_CAFE, 32'h0);

        // Requester-style read-modify-write loop on the last word.
        for (int i = 0; i < 3; i++) begin
            v = model[0][63];
            apply_stimulus(0, 1'b0, 32'hDEAD_CAFE, 32'h0);
            apply_stimulus(0, 1'b1, 32'hDEAD_CAFE, v + 32'd1);
        end
        apply_stimulus(0, 1'b0, 32'hDEAD_CAFE, 32'h0);
        check_output("rmw final model", model[0][63], 32'd3);

        idle(0, 3);
        check_output("dut0 queue drained", 32'(exp_q0.size()), 32'd0);
        check_output("dut1 queue drained", 32'(exp_q1.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
